// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding and operand-width legality.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int unsigned MIN_WIDTH = 2;

    function automatic bit width_legal(input int unsigned w);
        return w >= MIN_WIDTH;
    endfunction

endpackage

// File: rtl/fa_bit.sv
// One-bit combinational full adder; the per-bit datapath cell of the serial adder.
module fa_bit (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic s,
    output logic c
);

    assign s = x ^ y ^ z;
    assign c = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder computing a + b + cin LSB-first over WIDTH cycles with one full-adder cell.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             done_valid,
    input  logic             done_ready,
    output logic             busy
`ifdef SERIAL_ADDER_OVF_EN
   ,output logic             ovf
`endif
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    if (!width_legal(WIDTH)) begin : g_width_check
        $error("serial_adder: WIDTH must be at least 2");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             start_ready_q, done_valid_q, busy_q;
    logic             fa_s, fa_c;
    logic             last_bit;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    fa_bit u_fa (
        .x (sa_q[0]),
        .y (sb_q[0]),
        .z (carry_q),
        .s (fa_s),
        .c (fa_c)
    );

    assign last_bit = (cnt_q == CNT_LAST);

    // Next-state and datapath update; the counter holds on the last bit so it never wraps.
    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_valid) begin
                    sa_d    = a;
                    sb_d    = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sa_d    = {1'b0, sa_q[WIDTH-1:1]};
                sb_d    = {1'b0, sb_q[WIDTH-1:1]};
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                carry_d = fa_c;
                if (last_bit) begin
                    state_d = ST_DONE;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d   = carry_q ^ fa_c;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (done_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, datapath and registered handshake flags; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            sa_q          <= '0;
            sb_q          <= '0;
            sum_q         <= '0;
            cnt_q         <= '0;
            carry_q       <= 1'b0;
            start_ready_q <= 1'b1;
            done_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            sa_q          <= sa_d;
            sb_q          <= sb_d;
            sum_q         <= sum_d;
            cnt_q         <= cnt_d;
            carry_q       <= carry_d;
            start_ready_q <= (state_d == ST_IDLE);
            done_valid_q  <= (state_d == ST_DONE);
            busy_q        <= (state_d != ST_IDLE);
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q         <= ovf_d;
`endif
        end
    end

    assign start_ready = start_ready_q;
    assign done_valid  = done_valid_q;
    assign busy        = busy_q;
    assign sum         = sum_q;
    assign cout        = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf         = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 directed/random/corner cases and WIDTH=3 exhaustive.
module tb_serial_adder;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // WIDTH=8 instance
    logic       rst_n, start_valid, start_ready, cin, cout, done_valid, done_ready, busy;
    logic [7:0] a, b, sum;
    // WIDTH=3 instance
    logic       rst3_n, start_valid3, start_ready3, cin3, cout3, done_valid3, done_ready3, busy3;
    logic [2:0] a3, b3, sum3;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf, ovf3;
`endif

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
        .a(a), .b(b), .cin(cin), .sum(sum), .cout(cout),
        .done_valid(done_valid), .done_ready(done_ready), .busy(busy)
`ifdef SERIAL_ADDER_OVF_EN
       ,.ovf(ovf)
`endif
    );

    serial_adder #(.WIDTH(3)) dut3 (
        .clk(clk), .rst_n(rst3_n), .start_valid(start_valid3), .start_ready(start_ready3),
        .a(a3), .b(b3), .cin(cin3), .sum(sum3), .cout(cout3),
        .done_valid(done_valid3), .done_ready(done_ready3), .busy(busy3)
`ifdef SERIAL_ADDER_OVF_EN
       ,.ovf(ovf3)
`endif
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: integer addition; signed overflow when the signed sum leaves the W-bit range.
    function automatic int ref_sum(input int x, input int y, input int ci, input int w);
        return (x + y + ci) % (1 << (w + 1));
    endfunction

    function automatic int ref_ovf(input int x, input int y, input int ci, input int w);
        int half, sx, sy, r;
        half = 1 << (w - 1);
        sx = (x >= half) ? x - 2 * half : x;
        sy = (y >= half) ? y - 2 * half : y;
        r = sx + sy + ci;
        return (r >= half || r < -half) ? 1 : 0;
    endfunction

    logic cur_ovf;
    always_comb begin
`ifdef SERIAL_ADDER_OVF_EN
        cur_ovf = ovf;
`else
        cur_ovf = 1'b0;
`endif
    end

    task automatic check_reset8(input string tag);
        check({tag, " start_ready"}, start_ready, 1);
        check({tag, " done_valid"}, done_valid, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " sum"}, sum, 0);
        check({tag, " cout"}, cout, 0);
`ifdef SERIAL_ADDER_OVF_EN
        check({tag, " ovf"}, ovf, 0);
`endif
    endtask

    // Issue one request on the 8-bit DUT and wait (bounded) for done; returns latency in edges.
    task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input logic vc, output int lat);
        @(negedge clk);
        check("ready before accept", start_ready, 1);
        start_valid = 1'b1; a = va; b = vb; cin = vc; done_ready = 1'b0;
        @(posedge clk);
        #1;
        start_valid = 1'b0; a = ~va; b = ~vb; cin = ~vc;
        lat = -1;
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            if (k == 0) begin
                check("ready low after accept", start_ready, 0);
                check("busy after accept", busy, 1);
            end
            if (done_valid) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) check("done timeout", 0, 1);
    endtask

    task automatic release_done(input string tag);
        done_ready = 1'b1;
        @(negedge clk);
        done_ready = 1'b0;
        check({tag, " done cleared"}, done_valid, 0);
        check({tag, " back to idle"}, start_ready, 1);
        check({tag, " not busy"}, busy, 0);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, e, ia, ib, ic, idx, got, prev, pidx, hits;
        logic [7:0] ra, rb, hold_sum;
        logic rc, hold_cout, hold_ovf;

        rst_n = 1'b0; start_valid = 1'b0; a = '0; b = '0; cin = 1'b0; done_ready = 1'b0;
        rst3_n = 1'b0; start_valid3 = 1'b0; a3 = '0; b3 = '0; cin3 = 1'b0; done_ready3 = 1'b1;
        repeat (3) @(negedge clk);
        check_reset8("reset");
        check("reset3 start_ready", start_ready3, 1);
        check("reset3 done_valid", done_valid3, 0);
        rst_n = 1'b1; rst3_n = 1'b1;

        vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, lat);
            check($sformatf("vec%0d latency", i), lat, 8);
            check($sformatf("vec%0d sum", i), sum, vecs[i].sum);
            check($sformatf("vec%0d cout", i), cout, vecs[i].cout);
`ifdef SERIAL_ADDER_OVF_EN
            check($sformatf("vec%0d ovf", i), ovf, vecs[i].ovf);
`endif
            release_done($sformatf("vec%0d", i));
        end

        for (int i = 0; i < 30; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            run_op(ra, rb, rc, lat);
            e = ref_sum(int'(ra), int'(rb), int'(rc), 8);
            check($sformatf("rnd%0d latency", i), lat, 8);
            check($sformatf("rnd%0d cout_sum", i), {cout, sum}, 32'(e));
`ifdef SERIAL_ADDER_OVF_EN
            check($sformatf("rnd%0d ovf", i), ovf, 32'(ref_ovf(int'(ra), int'(rb), int'(rc), 8)));
`endif
            release_done($sformatf("rnd%0d", i));
        end

        // Back-pressure: DONE held with start_valid pulsing; outputs must not move.
        run_op(8'h5A, 8'h33, 1'b0, lat);
        hold_sum = sum; hold_cout = cout; hold_ovf = cur_ovf;
        check("bp sum", sum, 8'h8D);
        check("bp cout", cout, 0);
        for (int k = 0; k < 5; k++) begin
            start_valid = k[0] ? 1'b0 : 1'b1;
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
            @(negedge clk);
            check($sformatf("bp%0d sum stable", k), sum, hold_sum);
            check($sformatf("bp%0d cout stable", k), cout, hold_cout);
            check($sformatf("bp%0d ovf stable", k), cur_ovf, hold_ovf);
            check($sformatf("bp%0d done_valid", k), done_valid, 1);
            check($sformatf("bp%0d start_ready", k), start_ready, 0);
        end
        start_valid = 1'b0;
        release_done("bp");
        @(negedge clk);
        check("bp no second accept", busy, 0);

        // Reset during RUN cycle 3 discards the operation.
        @(negedge clk);
        start_valid = 1'b1; a = 8'hFF; b = 8'h00; cin = 1'b0;
        @(posedge clk);
        #1 start_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("pre-reset busy", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset8("mid reset");
        rst_n = 1'b1;
        hits = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done_valid) hits++;
        end
        check("no done after reset", hits, 0);
        run_op(8'h12, 8'h34, 1'b1, lat);
        check("post-reset latency", lat, 8);
        check("post-reset sum", sum, 8'h47);
        check("post-reset cout", cout, 0);
        release_done("post-reset");

        // WIDTH=3 exhaustive, back-to-back with done_ready held high.
        idx = 0; got = 0; prev = -1; pidx = 0;
        for (int k = 0; k < 2000 && got < 128; k++) begin
            @(negedge clk);
            if (done_valid3) begin
                ia = pidx % 8; ib = (pidx / 8) % 8; ic = pidx / 64;
                check($sformatf("w3 #%0d cout_sum", pidx), {cout3, sum3}, 32'(ref_sum(ia, ib, ic, 3)));
`ifdef SERIAL_ADDER_OVF_EN
                check($sformatf("w3 #%0d ovf", pidx), ovf3, 32'(ref_ovf(ia, ib, ic, 3)));
`endif
                got++;
            end
            if (start_ready3) begin
                if (idx < 128) begin
                    a3 = 3'(idx % 8); b3 = 3'((idx / 8) % 8); cin3 = 1'(idx / 64);
                    start_valid3 = 1'b1;
                    if (prev >= 0) check($sformatf("w3 interval #%0d", idx), cyc - prev, 5);
                    prev = cyc;
                    pidx = idx;
                    idx++;
                end else begin
                    start_valid3 = 1'b0;
                end
            end
        end
        start_valid3 = 1'b0;
        check("w3 results received", got, 128);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial ripple adder that computes `a + b + cin` LSB-first over `WIDTH` clock cycles, using one full-adder cell and a registered carry. It sits downstream of the combinational full-adder stage and reuses that cell as its per-bit datapath. It is the area-minimal adder for wide operands where latency is acceptable. Operands enter through a valid/ready request handshake; the result leaves through a valid/ready response handshake.

## Interface
- `WIDTH`, default 8: operand and sum width in bits; legal range is `WIDTH >= 2`.
- `clk`  in  1  the single clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `start_valid`  in  1  request: operands are present.
- `start_ready`  out  1  block can accept a request; high only in IDLE.
- `a`  in  WIDTH  operand A, sampled only on request accept.
- `b`  in  WIDTH  operand B, sampled only on request accept.
- `cin`  in  1  carry-in, sampled only on request accept.
- `sum`  out  WIDTH  result; meaningful only while `done_valid` is high.
- `cout`  out  1  carry-out; meaningful only while `done_valid` is high.
- `done_valid`  out  1  result is available.
- `done_ready`  in  1  consumer takes the result.
- `busy`  out  1  high in RUN or DONE.
- `ovf`  out  1  signed overflow; present only with `SERIAL_ADDER_OVF_EN` defined.

## Operation
- The FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - `start_ready=1`.
  - On `start_valid && start_ready`: load shift registers `sa<=a` and `sb<=b`, set `carry<=cin`, set `cnt<=0`, and go to RUN.
- RUN, every cycle:
  - `{c,s} = fa(sa[0], sb[0], carry)`.
  - Shift `sa` and `sb` right by one.
  - Shift `s` into the MSB of the sum shift register, so after `WIDTH` shifts bit 0 holds the first computed bit.
  - `carry<=c`, `cnt<=cnt+1`.
  - In the cycle where `cnt==WIDTH-1`, go to DONE after the update.
- DONE:
  - `done_valid=1`.
  - `sum`, `cout`, and `ovf` hold stable.
  - On `done_ready`, go to IDLE.
- `cout` is the final carry register value.
- `start_valid` is ignored outside IDLE. Operand inputs are don't-care outside the accept cycle.
- Arithmetic is unsigned modulo `2^WIDTH`; overflow out of the top bit appears only on `cout`.
- `cnt` width is `$clog2(WIDTH)`, and it never wraps inside an operation.
- Reset mid-operation (RUN or DONE) discards the operation and returns to IDLE with no result emitted.

## Timing
- Reset values: state IDLE, `start_ready=1`, `done_valid=0`, `busy=0`, `sum=0`, `cout=0`, `ovf=0`.
- Outputs are registered or decoded from state only; there is no combinational path from input to output.
- Latency: request accepted at edge 0 → `done_valid` high after edge `WIDTH`.
- Minimum issue interval is `WIDTH+2` cycles: one IDLE accept cycle, `WIDTH` RUN cycles, and one DONE cycle with `done_ready=1`.
- `start_ready` is low from the edge after accept until the edge that completes the done handshake.
- Back-pressure: `done_ready=0` holds DONE indefinitely and the outputs do not change.
- Simultaneous `rst_n=0` with any handshake: reset wins.

## Configuration
- Macro: `SERIAL_ADDER_OVF_EN`.
- Defined:
  - Adds the `ovf` port.
  - On the last RUN cycle (`cnt==WIDTH-1`), `ovf<=carry ^ c`, i.e. carry into the MSB XOR carry out of the MSB.
  - `ovf` is held through DONE and cleared on reset.
- Undefined: no `ovf` port and no overflow register. All other behaviour is identical.

## Structure
- `serial_adder_pkg` holds:
  - the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the `WIDTH` legality check constant.
- Sub-module `fa_bit` is the one-bit full adder, purely combinational: inputs `x`, `y`, `z`; outputs `s`, `c`. It is instantiated once in the RUN datapath.
- The top level holds the FSM, counter, shift registers, carry register, and optional overflow register.

## Test plan
- WIDTH=8, accept `a=8'h00`, `b=8'h00`, `cin=0` → `done_valid` exactly 8 cycles after accept, with `sum=8'h00`, `cout=0`.
- `a=8'hFF`, `b=8'h01`, `cin=0` → `sum=8'h00`, `cout=1` (wrap-around).
- With `SERIAL_ADDER_OVF_EN`:
  - `a=8'h7F`, `b=8'h01` → `sum=8'h80`, `cout=0`, `ovf=1`.
  - `a=8'hFF`, `b=8'h01` → `ovf=0`.
- Back-pressure:
  - Hold `done_ready=0` for 5 cycles in DONE while pulsing `start_valid` → `sum` and `cout` stable, `start_ready=0`, second request not accepted.
  - Release `done_ready` → IDLE next cycle.
- Reset recovery:
  - Drop `rst_n` on RUN cycle 3 → next cycle IDLE, all outputs at reset values, no `done_valid`.
  - Then `a=8'h12`, `b=8'h34`, `cin=1` → `sum=8'h47`, `cout=0`.
- WIDTH=3 exhaustive: all 128 combinations of `a`, `b`, `cin`, issued back-to-back with `done_ready=1` → `{cout,sum}==a+b+cin` for every combination, and the issue interval is 5 cycles.
